// File: rtl/render_pkg.sv
// ---------------------------------------------------------------------------
// render_pkg
// Shared definitions for the line render scheduler: scheduler state encoding
// and the default frame geometry / pipeline timing parameters.
// ---------------------------------------------------------------------------
package render_pkg;

    // Scheduler states
    typedef enum logic [1:0] {
        IDLE       = 2'd0,  // waiting for the frame pre-render pulse
        RENDER     = 2'd1,  // feeding X coordinates into the render pipeline
        WAIT_LINES = 2'd2   // line finished, waiting for its scanlines to elapse
    } sched_state_t;

    // Default geometry and timing
    localparam int DEF_H_PIXELS    = 400;  // pixels rendered per line
    localparam int DEF_V_LINES     = 300;  // rendered lines per frame
    localparam int DEF_PIPE_DEPTH  = 3;    // render pipeline latency (cycles)
    localparam int DEF_LINE_REPEAT = 2;    // VGA scanlines per rendered line

endpackage

// File: rtl/line_render_scheduler.sv
// ---------------------------------------------------------------------------
// line_render_scheduler
// Schedules rendering of one line at a time into a double-buffered line RAM.
// Each rendered line is shown for LINE_REPEAT VGA scanlines; while the
// current line is displayed the next one is rendered into the other half of
// the line RAM (selected by work_y[0]). If the scanlines elapse before the
// render has finished, the line is abandoned and the sticky underrun flag is
// raised.
//
// Ports
//   clk             in   pixel clock
//   rst_n           in   synchronous active-low reset
//   line_start      in   one-cycle pulse at each VGA scanline start
//   frame_prerender in   one-cycle pulse one scanline before the first visible line
//   underrun_clr    in   clears the underrun flag
//   work_x   [8:0]  out  render pipeline input X coordinate
//   work_y   [8:0]  out  line being rendered
//   work_en         out  render pipeline input valid
//   wr_en           out  line-RAM write strobe
//   wr_addr  [9:0]  out  line-RAM write address {work_y[0], pixel index}
//   line_done       out  pulse when the last pixel of a line is written
//   underrun        out  sticky flag: render missed its deadline
// ---------------------------------------------------------------------------
module line_render_scheduler
    import render_pkg::*;
#(
    parameter int H_PIXELS    = DEF_H_PIXELS,
    parameter int V_LINES     = DEF_V_LINES,
    parameter int PIPE_DEPTH  = DEF_PIPE_DEPTH,
    parameter int LINE_REPEAT = DEF_LINE_REPEAT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       line_start,
    input  logic       frame_prerender,
    input  logic       underrun_clr,
    output logic [8:0] work_x,
    output logic [8:0] work_y,
    output logic       work_en,
    output logic       wr_en,
    output logic [9:0] wr_addr,
    output logic       line_done,
    output logic       underrun
);

    localparam int         CNT_W    = $clog2(LINE_REPEAT + 1);
    localparam logic [8:0] X_LAST   = 9'(H_PIXELS + PIPE_DEPTH - 1);
    localparam logic [8:0] Y_LAST   = 9'(V_LINES - 1);
    localparam logic [8:0] PIPE_LAT = 9'(PIPE_DEPTH);
    localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(LINE_REPEAT - 1);

    sched_state_t     state;
    logic [CNT_W-1:0] ls_cnt;

    logic       ls_hit;
    logic       cnt_reach;
    logic       underrun_set;
    logic [8:0] pix_idx;

    // frame_prerender takes priority: a coincident line_start is dropped.
    assign ls_hit       = line_start && !frame_prerender;
    // The scanline budget for this line expires on this pulse.
    assign cnt_reach    = ls_hit && (ls_cnt == CNT_PENULT);
    assign underrun_set = (state != IDLE) &&
                          (frame_prerender || (state == RENDER && cnt_reach));

    // Outputs are decoded from registered state; gating with rst_n makes a
    // reset abort the pipeline feed in the same cycle it is asserted.
    assign work_en   = rst_n && (state == RENDER);
    assign wr_en     = work_en && (work_x >= PIPE_LAT);
    assign pix_idx   = work_x - PIPE_LAT;
    assign wr_addr   = wr_en ? {work_y[0], pix_idx} : 10'd0;
    assign line_done = work_en && (work_x == X_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            work_x   <= 9'd0;
            work_y   <= 9'd0;
            ls_cnt   <= '0;
            underrun <= 1'b0;
        end else begin
            // Set wins over clear.
            if (underrun_set) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (frame_prerender) begin
                        state  <= RENDER;
                        work_x <= 9'd0;
                        work_y <= 9'd0;
                        ls_cnt <= '0;
                    end
                end

                RENDER, WAIT_LINES: begin
                    if (frame_prerender) begin
                        // Frame restart while busy: start over from line 0.
                        state  <= RENDER;
                        work_x <= 9'd0;
                        work_y <= 9'd0;
                        ls_cnt <= '0;
                    end else if (cnt_reach) begin
                        // Scanlines for this line are over; move on, whether
                        // or not the render had finished.
                        work_x <= 9'd0;
                        ls_cnt <= '0;
                        if (work_y < Y_LAST) begin
                            work_y <= work_y + 9'd1;
                            state  <= RENDER;
                        end else begin
                            state  <= IDLE;
                        end
                    end else begin
                        if (ls_hit) begin
                            ls_cnt <= ls_cnt + 1'b1;
                        end
                        if (state == RENDER) begin
                            if (work_x == X_LAST) begin
                                work_x <= 9'd0;
                                state  <= WAIT_LINES;
                            end else begin
                                work_x <= work_x + 9'd1;
                            end
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_render_scheduler.sv
// ---------------------------------------------------------------------------
// tb_line_render_scheduler
// Directed bench for line_render_scheduler with default parameters. A
// behavioural model tracks the render schedule in terms of "cycles since the
// line started", the current line and the scanline pulses seen, and is
// compared against the DUT on every falling edge. Directed literal checks
// pin down the key numbers of the schedule.
// ---------------------------------------------------------------------------
module tb_line_render_scheduler;

    localparam int H = 400;
    localparam int V = 300;
    localparam int P = 3;
    localparam int R = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       line_start = 1'b0;
    logic       frame_prerender = 1'b0;
    logic       underrun_clr = 1'b0;
    logic [8:0] work_x;
    logic [8:0] work_y;
    logic       work_en;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic       line_done;
    logic       underrun;

    int checks = 0;
    int failures = 0;

    line_render_scheduler #(
        .H_PIXELS   (H),
        .V_LINES    (V),
        .PIPE_DEPTH (P),
        .LINE_REPEAT(R)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .line_start     (line_start),
        .frame_prerender(frame_prerender),
        .underrun_clr   (underrun_clr),
        .work_x         (work_x),
        .work_y         (work_y),
        .work_en        (work_en),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .line_done      (line_done),
        .underrun       (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     nm, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_mode: 0 = not rendering, 1 = rendering, 2 = waiting for scanlines
    int m_mode = 0;
    int m_t    = 0;   // cycles since the current line started rendering
    int m_y    = 0;
    int m_seen = 0;   // scanline pulses seen since this line started
    int m_und  = 0;
    bit chk_on = 1'b0;

    always @(posedge clk) begin
        bit set_u;
        set_u = 1'b0;
        if (!rst_n) begin
            m_mode = 0; m_t = 0; m_y = 0; m_seen = 0; m_und = 0;
            chk_on = 1'b1;
        end else begin
            if (frame_prerender) begin
                if (m_mode != 0) set_u = 1'b1;
                m_mode = 1; m_t = 0; m_y = 0; m_seen = 0;
            end else if (m_mode != 0) begin
                if (line_start) m_seen++;
                if (m_seen == R) begin
                    if (m_mode == 1) set_u = 1'b1;
                    m_seen = 0; m_t = 0;
                    if (m_y < V - 1) begin
                        m_y++; m_mode = 1;
                    end else begin
                        m_mode = 0;
                    end
                end else if (m_mode == 1) begin
                    if (m_t == H + P - 1) begin
                        m_mode = 2; m_t = 0;
                    end else begin
                        m_t++;
                    end
                end
            end
            if (set_u) m_und = 1;
            else if (underrun_clr) m_und = 0;
        end
    end

    always @(negedge clk) begin
        int e_en, e_wr, e_addr, e_ld;
        if (chk_on) begin
            e_en   = (rst_n && m_mode == 1) ? 1 : 0;
            e_wr   = (e_en == 1 && m_t >= P) ? 1 : 0;
            e_addr = e_wr ? ((m_y % 2) * 512 + m_t - P) : 0;
            e_ld   = (e_en == 1 && m_t == H + P - 1) ? 1 : 0;
            check("model_work_en", int'(work_en), e_en);
            check("model_work_x", int'(work_x), m_t);
            check("model_work_y", int'(work_y), m_y);
            check("model_wr_en", int'(wr_en), e_wr);
            check("model_wr_addr", int'(wr_addr), e_addr);
            check("model_line_done", int'(line_done), e_ld);
            check("model_underrun", int'(underrun), m_und);
        end
    end

    // ---------------- activity monitor ----------------
    int en_cnt, wr_cnt, ld_cnt, ld_x, first_addr, last_addr, first_wr_x;
    bit seen_wr;

    always @(negedge clk) begin
        if (work_en) en_cnt++;
        if (wr_en) begin
            if (!seen_wr) begin
                first_addr = int'(wr_addr);
                first_wr_x = int'(work_x);
                seen_wr = 1'b1;
            end
            last_addr = int'(wr_addr);
            wr_cnt++;
        end
        if (line_done) begin
            ld_cnt++;
            ld_x = int'(work_x);
        end
    end

    task automatic clr_mon();
        en_cnt = 0; wr_cnt = 0; ld_cnt = 0; ld_x = -1;
        first_addr = -1; last_addr = -1; first_wr_x = -1; seen_wr = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_ls();
        line_start = 1'b1;
        step();
        line_start = 1'b0;
    endtask

    task automatic pulse_fp();
        frame_prerender = 1'b1;
        step();
        frame_prerender = 1'b0;
    endtask

    task automatic pulse_clr();
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
    endtask

    // Abandon lines quickly (two scanline pulses while rendering) until the
    // target line is reached; bounded so a broken DUT cannot hang the run.
    task automatic skip_to(input int target);
        int guard;
        guard = 0;
        while (int'(work_y) < target && guard < 400) begin
            pulse_ls();
            pulse_ls();
            guard++;
        end
        check("skip_to_line", int'(work_y), target);
    endtask

    initial begin
        clr_mon();

        // Reset
        steps(3);
        check("rst_work_en", int'(work_en), 0);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_line_done", int'(line_done), 0);
        check("rst_underrun", int'(underrun), 0);
        check("rst_work_x", int'(work_x), 0);
        rst_n = 1'b1;
        steps(2);
        check("idle_work_en", int'(work_en), 0);

        // Line 0: full render
        clr_mon();
        pulse_fp();
        check("fp_work_en", int'(work_en), 1);
        check("fp_work_x", int'(work_x), 0);
        check("fp_work_y", int'(work_y), 0);
        steps(410);
        check("l0_en_cycles", en_cnt, 403);
        check("l0_wr_cycles", wr_cnt, 400);
        check("l0_first_wr_x", first_wr_x, 3);
        check("l0_first_addr", first_addr, 'h000);
        check("l0_last_addr", last_addr, 'h18F);
        check("l0_line_done_cnt", ld_cnt, 1);
        check("l0_line_done_x", ld_x, 402);
        check("l0_wait_en", int'(work_en), 0);

        // Line 1 after two scanline pulses
        clr_mon();
        pulse_ls();
        step();
        pulse_ls();
        check("l1_work_y", int'(work_y), 1);
        steps(410);
        check("l1_wr_cycles", wr_cnt, 400);
        check("l1_first_addr", first_addr, 'h200);
        check("l1_last_addr", last_addr, 'h38F);
        check("l1_underrun", int'(underrun), 0);

        // Underrun: scanlines elapse mid-render on line 2
        pulse_ls();
        pulse_ls();
        check("l2_work_y", int'(work_y), 2);
        clr_mon();
        steps(98);
        pulse_ls();
        pulse_ls();
        check("ur_underrun", int'(underrun), 1);
        check("ur_work_y", int'(work_y), 3);
        check("ur_work_x", int'(work_x), 0);
        check("ur_no_line_done", ld_cnt, 0);
        pulse_clr();
        check("ur_clr_alone", int'(underrun), 0);

        // Clear concurrent with a new underrun: set wins
        steps(5);
        pulse_ls();
        line_start = 1'b1;
        underrun_clr = 1'b1;
        step();
        line_start = 1'b0;
        underrun_clr = 1'b0;
        check("ur_set_wins", int'(underrun), 1);
        check("ur2_work_y", int'(work_y), 4);
        pulse_clr();
        check("ur_clr_after", int'(underrun), 0);

        // frame_prerender + line_start together while waiting on line 57
        skip_to(57);
        steps(410);
        check("y57_waiting", int'(work_en), 0);
        pulse_clr();
        frame_prerender = 1'b1;
        line_start = 1'b1;
        step();
        frame_prerender = 1'b0;
        line_start = 1'b0;
        check("fpls_work_y", int'(work_y), 0);
        check("fpls_work_en", int'(work_en), 1);
        check("fpls_work_x", int'(work_x), 0);
        check("fpls_underrun", int'(underrun), 1);
        pulse_clr();
        pulse_ls();
        check("fpls_ls_ignored_und", int'(underrun), 0);
        check("fpls_ls_ignored_y", int'(work_y), 0);

        // Reset in the middle of a render
        steps(20);
        rst_n = 1'b0;
        #1;
        check("midrst_work_en", int'(work_en), 0);
        check("midrst_wr_en", int'(wr_en), 0);
        step();
        rst_n = 1'b1;
        clr_mon();
        steps(20);
        pulse_ls();
        pulse_ls();
        check("midrst_no_wr", wr_cnt, 0);
        check("midrst_no_en", en_cnt, 0);

        // Last line of the frame, then back to idle
        pulse_fp();
        skip_to(299);
        pulse_clr();
        clr_mon();
        steps(410);
        check("l299_wr_cycles", wr_cnt, 400);
        check("l299_first_addr", first_addr, 'h200);
        check("l299_last_addr", last_addr, 'h38F);
        check("l299_line_done", ld_cnt, 1);
        pulse_ls();
        pulse_ls();
        check("eof_work_en", int'(work_en), 0);
        check("eof_underrun", int'(underrun), 0);
        clr_mon();
        steps(5);
        pulse_ls();
        pulse_ls();
        steps(3);
        check("eof_stays_idle", en_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_render_scheduler.md
LINE_RENDER_SCHEDULER -- requirements
Module: line_render_scheduler

Interface
REQ-001 SHALL have parameter H_PIXELS, default 400: pixels rendered per line.
REQ-002 SHALL have parameter V_LINES, default 300: rendered lines per frame.
REQ-003 SHALL have parameter PIPE_DEPTH, default 3: render pipeline latency in cycles.
REQ-004 SHALL have parameter LINE_REPEAT, default 2: VGA scanlines per rendered line.
REQ-005 SHALL have port clk, input, 1: pixel clock, the single clock.
REQ-006 SHALL have port rst_n, input, 1: synchronous active-low reset.
REQ-007 SHALL have port line_start, input, 1: one-cycle pulse at each VGA scanline start.
REQ-008 SHALL have port frame_prerender, input, 1: one-cycle pulse one scanline before the first visible line.
REQ-009 SHALL have port underrun_clr, input, 1: clears the underrun flag.
REQ-010 SHALL have port work_x, output, 9: pipeline-input X coordinate.
REQ-011 SHALL have port work_y, output, 9: line being rendered.
REQ-012 SHALL have port work_en, output, 1: pipeline-input valid.
REQ-013 SHALL have port wr_en, output, 1: line-RAM write strobe.
REQ-014 SHALL have port wr_addr, output, 10: line-RAM write address {work_y[0], pixel index}.
REQ-015 SHALL have port line_done, output, 1: one-cycle pulse when the last pixel of a line is written.
REQ-016 SHALL have port underrun, output, 1: sticky flag, render missed its deadline.

Function
REQ-017 SHALL implement an FSM with states IDLE, RENDER and WAIT_LINES.
- IDLE: waits for frame_prerender.
- RENDER: increments work_x once per cycle.
- WAIT_LINES: counts line_start pulses.
REQ-018 IDLE + frame_prerender SHALL give work_y=0, work_x=0, line-start count=0, next state RENDER.
REQ-019 In RENDER, work_en SHALL be 1 and work_x SHALL step 0 .. H_PIXELS+PIPE_DEPTH-1, one step per cycle.
- After the last value: work_x returns to 0 and the FSM enters WAIT_LINES.
REQ-020 wr_en SHALL be 1 exactly when work_en=1 and work_x >= PIPE_DEPTH.
- In that case wr_addr = {work_y[0], work_x - PIPE_DEPTH}.
- Otherwise wr_addr = 0.
REQ-021 wr_en, wr_addr, work_x, work_y and work_en SHALL be combinational from registered state; write latency 0 relative to work_x.
REQ-022 line_done SHALL pulse in the cycle where work_x = H_PIXELS+PIPE_DEPTH-1.
REQ-023 line_start pulses SHALL be counted from RENDER entry, in both RENDER and WAIT_LINES.
REQ-024 When the count reaches LINE_REPEAT in WAIT_LINES:
- if work_y < V_LINES-1: work_y increments, count clears, next state RENDER;
- otherwise: next state IDLE.
REQ-025 When the count reaches LINE_REPEAT while still in RENDER:
- underrun SHALL be set;
- the remaining pixels are abandoned, with no line_done;
- the FSM advances exactly as in REQ-024.
REQ-026 frame_prerender in RENDER or WAIT_LINES SHALL set underrun and force work_y=0, work_x=0, count=0, state RENDER.
REQ-027 If frame_prerender and line_start occur in the same cycle, frame_prerender SHALL win and line_start SHALL be ignored.
REQ-028 If underrun_clr and an underrun event occur in the same cycle, underrun SHALL be 1 (set wins).
REQ-029 Arithmetic widths:
- work_x and work_y: 9-bit, no wrap with default parameters;
- line-start count: $clog2(LINE_REPEAT+1) bits.

Reset
REQ-030 While rst_n=0 at a clk edge, the following SHALL clear: state=IDLE, work_x=0, work_y=0, count=0, underrun=0.
REQ-031 During and after reset, work_en, wr_en, wr_addr and line_done SHALL read 0.
REQ-032 Reset asserted mid-RENDER SHALL abort the line immediately, and no further wr_en SHALL occur until the next frame_prerender.

Structure
REQ-033 Package render_pkg SHALL hold the state typedef and the default values of H_PIXELS, V_LINES, PIPE_DEPTH and LINE_REPEAT.
REQ-034 The block SHALL be a single module with no sub-modules.

Verification
REQ-035 Reset, then frame_prerender -> next cycle work_en=1, work_x=0, work_y=0; first wr_en at work_x=3 with wr_addr=0x000.
REQ-036 Full line y=0 -> 403 work_en cycles, 400 wr_en cycles with wr_addr 0x000..0x18F, line_done at work_x=402.
REQ-037 Line y=1 after 2 line_start pulses -> wr_addr 0x200..0x38F; after line y=299 plus 2 line_start pulses -> state IDLE, work_en=0.
REQ-038 2 line_start pulses at cycle 100 of RENDER -> underrun=1, no line_done, work_y incremented, work_x=0.
REQ-039 frame_prerender and line_start in the same cycle during WAIT_LINES at y=57 -> work_y=0, RENDER, count=0, underrun=1.
REQ-040 underrun_clr concurrent with a new underrun -> underrun stays 1; underrun_clr alone -> 0 next cycle.
